// File: rtl/axi4_r_resp_gen_if.sv
// Command and R-channel bundle for the locally terminated read response generator.
// The generator side uses the master modport; the consumer/stimulus side uses slave.
interface axi4_r_resp_gen_if #(
    parameter int unsigned AXI_ID_WIDTH   = 4,
    parameter int unsigned AXI_USER_WIDTH = 4,
    parameter int unsigned AXI_DATA_WIDTH = 64,
    parameter int unsigned CMD_DEPTH      = 4
) ();

    // Command push side
    logic                          cmd_valid;
    logic                          cmd_ready;
    logic [AXI_ID_WIDTH-1:0]       cmd_id;
    logic [7:0]                    cmd_len;
    logic [AXI_USER_WIDTH-1:0]     cmd_user;
    logic [1:0]                    cmd_resp;

    // R channel
    logic [AXI_ID_WIDTH-1:0]       m_axi4_rid;
    logic [AXI_DATA_WIDTH-1:0]     m_axi4_rdata;
    logic [1:0]                    m_axi4_rresp;
    logic                          m_axi4_rlast;
    logic [AXI_USER_WIDTH-1:0]     m_axi4_ruser;
    logic                          m_axi4_rvalid;
    logic                          m_axi4_rready;

    // Status
    logic                          busy;
    logic [$clog2(CMD_DEPTH):0]    cmd_count;

    modport master (
        input  cmd_valid, cmd_id, cmd_len, cmd_user, cmd_resp, m_axi4_rready,
        output cmd_ready, m_axi4_rid, m_axi4_rdata, m_axi4_rresp, m_axi4_rlast,
        output m_axi4_ruser, m_axi4_rvalid, busy, cmd_count
    );

    modport slave (
        output cmd_valid, cmd_id, cmd_len, cmd_user, cmd_resp, m_axi4_rready,
        input  cmd_ready, m_axi4_rid, m_axi4_rdata, m_axi4_rresp, m_axi4_rlast,
        input  m_axi4_ruser, m_axi4_rvalid, busy, cmd_count
    );

endinterface

// File: rtl/axi4_r_resp_gen.sv
// Generates complete zero-data AXI4 R bursts for reads terminated locally
// (translation misses, protection faults, dropped requests). Commands are
// queued in a small FIFO; the head command is replayed as len+1 beats.
module axi4_r_resp_gen #(
    parameter int unsigned AXI_ID_WIDTH   = 4,
    parameter int unsigned AXI_USER_WIDTH = 4,
    parameter int unsigned AXI_DATA_WIDTH = 64,
    parameter int unsigned CMD_DEPTH      = 4
) (
    input  logic              axi4_aclk,
    input  logic              axi4_arst,
    axi4_r_resp_gen_if.master bus
);

    localparam int unsigned PtrWidth = $clog2(CMD_DEPTH);
    localparam int unsigned CntWidth = PtrWidth + 1;

    typedef enum logic [0:0] {StIdle, StSend} state_e;

    // Command storage, one array per field
    logic [AXI_ID_WIDTH-1:0]   id_q   [CMD_DEPTH];
    logic [7:0]                len_q  [CMD_DEPTH];
    logic [AXI_USER_WIDTH-1:0] user_q [CMD_DEPTH];
    logic [1:0]                resp_q [CMD_DEPTH];

    logic [PtrWidth-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrWidth-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntWidth-1:0] count_q, count_d;
    logic [7:0]          beat_cnt_q, beat_cnt_d;
    state_e              state_q, state_d;

    logic cmd_ready;
    logic push;
    logic pop;
    logic rvalid;
    logic hs;
    logic last_beat;

    // No full-bypass: a pop in the same cycle does not open the FIFO early.
    assign cmd_ready = (count_q != CntWidth'(CMD_DEPTH));
    assign push      = bus.cmd_valid & cmd_ready;
    assign rvalid    = (state_q == StSend);
    assign last_beat = (beat_cnt_q == len_q[rd_ptr_q]);
    assign hs        = rvalid & bus.m_axi4_rready;
    assign pop       = hs & last_beat;

    // Pointer and occupancy next-state
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PtrWidth'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PtrWidth'(1);
        end
        if (push && !pop) begin
            count_d = count_q + CntWidth'(1);
        end else if (!push && pop) begin
            count_d = count_q - CntWidth'(1);
        end
    end

    // Burst FSM next-state; looking at count_d lets a fresh push raise rvalid
    // next cycle and lets a following command start without a bubble.
    always_comb begin
        state_d    = state_q;
        beat_cnt_d = beat_cnt_q;
        unique case (state_q)
            StIdle: begin
                if (count_d != '0) begin
                    state_d = StSend;
                end
            end
            StSend: begin
                if (hs) begin
                    if (!last_beat) begin
                        beat_cnt_d = beat_cnt_q + 8'd1;
                    end else begin
                        beat_cnt_d = 8'd0;
                        if (count_d == '0) begin
                            state_d = StIdle;
                        end
                    end
                end
            end
            default: begin
                state_d    = StIdle;
                beat_cnt_d = 8'd0;
            end
        endcase
    end

    // Control state registers
    always_ff @(posedge axi4_aclk or posedge axi4_arst) begin
        if (axi4_arst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            beat_cnt_q <= 8'd0;
            state_q    <= StIdle;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            beat_cnt_q <= beat_cnt_d;
            state_q    <= state_d;
        end
    end

    // Command payload write; contents are don't-care until pointed at by a valid count
    always_ff @(posedge axi4_aclk) begin
        if (push) begin
            id_q[wr_ptr_q]   <= bus.cmd_id;
            len_q[wr_ptr_q]  <= bus.cmd_len;
            user_q[wr_ptr_q] <= bus.cmd_user;
            resp_q[wr_ptr_q] <= bus.cmd_resp;
        end
    end

    // Outputs; payload is gated so stale FIFO contents never leak while idle
    always_comb begin
        bus.cmd_ready     = cmd_ready;
        bus.m_axi4_rvalid = rvalid;
        bus.m_axi4_rlast  = rvalid & last_beat;
        bus.m_axi4_rdata  = '0;
        bus.m_axi4_rid    = rvalid ? id_q[rd_ptr_q]   : '0;
        bus.m_axi4_rresp  = rvalid ? resp_q[rd_ptr_q] : 2'b00;
        bus.m_axi4_ruser  = rvalid ? user_q[rd_ptr_q] : '0;
        bus.busy          = (count_q != '0);
        bus.cmd_count     = count_q;
    end

endmodule

// File: tb/tb_axi4_r_resp_gen.sv
// Directed bench for axi4_r_resp_gen: inputs change on the falling edge,
// outputs are checked on the falling edge, handshakes happen on the rising edge.
module tb_axi4_r_resp_gen;

    logic clk;
    logic rst;
    int   n_vec;
    int   n_err;

    axi4_r_resp_gen_if bus_if ();

    axi4_r_resp_gen dut (
        .axi4_aclk (clk),
        .axi4_arst (rst),
        .bus       (bus_if)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Push one command; starts and ends on a falling edge.
    task automatic push_cmd(input logic [3:0] id, input logic [7:0] len,
                            input logic [3:0] user, input logic [1:0] resp);
        int waited;
        waited = 0;
        bus_if.cmd_valid = 1'b1;
        bus_if.cmd_id    = id;
        bus_if.cmd_len   = len;
        bus_if.cmd_user  = user;
        bus_if.cmd_resp  = resp;
        while (!bus_if.cmd_ready && waited < 600) begin
            @(posedge clk);
            @(negedge clk);
            waited++;
        end
        check_eq("push_ready", bus_if.cmd_ready, 1);
        @(posedge clk);
        @(negedge clk);
        bus_if.cmd_valid = 1'b0;
    endtask

    // Consume one burst; rvalid must be high on every cycle of it.
    task automatic recv_burst(input logic [3:0] id, input logic [7:0] len,
                              input logic [3:0] user, input logic [1:0] resp,
                              input bit toggle);
        int   beats;
        int   cyc;
        logic hs;
        beats = 0;
        cyc   = 0;
        while (beats <= int'(len) && cyc < 600) begin
            bus_if.m_axi4_rready = toggle ? ((cyc % 2) == 0) : 1'b1;
            check_eq("rvalid", bus_if.m_axi4_rvalid, 1);
            check_eq("rid",    bus_if.m_axi4_rid,    id);
            check_eq("ruser",  bus_if.m_axi4_ruser,  user);
            check_eq("rresp",  bus_if.m_axi4_rresp,  resp);
            check_eq("rdata",  bus_if.m_axi4_rdata,  0);
            check_eq("rlast",  bus_if.m_axi4_rlast,  beats == int'(len));
            hs = bus_if.m_axi4_rvalid & bus_if.m_axi4_rready;
            @(posedge clk);
            @(negedge clk);
            if (hs) beats++;
            cyc++;
        end
        bus_if.m_axi4_rready = 1'b0;
        check_eq("beats", beats, int'(len) + 1);
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst = 1'b1;
        bus_if.cmd_valid     = 1'b0;
        bus_if.cmd_id        = '0;
        bus_if.cmd_len       = '0;
        bus_if.cmd_user      = '0;
        bus_if.cmd_resp      = '0;
        bus_if.m_axi4_rready = 1'b0;

        // Reset state
        @(negedge clk);
        check_eq("rst_cmd_ready", bus_if.cmd_ready, 1);
        check_eq("rst_rvalid",    bus_if.m_axi4_rvalid, 0);
        check_eq("rst_rlast",     bus_if.m_axi4_rlast, 0);
        check_eq("rst_busy",      bus_if.busy, 0);
        check_eq("rst_count",     bus_if.cmd_count, 0);
        check_eq("rst_rid",       bus_if.m_axi4_rid, 0);
        check_eq("rst_rresp",     bus_if.m_axi4_rresp, 0);
        check_eq("rst_ruser",     bus_if.m_axi4_ruser, 0);
        @(negedge clk);
        rst = 1'b0;

        // Single len=0 command: one beat next cycle, busy drops after handshake
        push_cmd(4'd3, 8'd0, 4'd5, 2'b10);
        check_eq("t1_busy", bus_if.busy, 1);
        check_eq("t1_count", bus_if.cmd_count, 1);
        recv_burst(4'd3, 8'd0, 4'd5, 2'b10, 1'b0);
        check_eq("t1_rvalid_after", bus_if.m_axi4_rvalid, 0);
        check_eq("t1_busy_after", bus_if.busy, 0);

        // len=3 with rready toggling
        push_cmd(4'd1, 8'd3, 4'd2, 2'b00);
        recv_burst(4'd1, 8'd3, 4'd2, 2'b00, 1'b1);
        check_eq("t2_rvalid_after", bus_if.m_axi4_rvalid, 0);
        // A following len=0 command must flag rlast on its first beat
        push_cmd(4'd8, 8'd0, 4'd9, 2'b01);
        recv_burst(4'd8, 8'd0, 4'd9, 2'b01, 1'b0);

        // Fill the FIFO, fifth command waits for the first pop
        push_cmd(4'd10, 8'd0, 4'd1, 2'b11);
        push_cmd(4'd11, 8'd1, 4'd2, 2'b10);
        push_cmd(4'd12, 8'd2, 4'd3, 2'b01);
        push_cmd(4'd13, 8'd0, 4'd4, 2'b00);
        check_eq("t3_count_full", bus_if.cmd_count, 4);
        check_eq("t3_ready_full", bus_if.cmd_ready, 0);
        check_eq("t3_rid_head", bus_if.m_axi4_rid, 10);
        bus_if.cmd_valid = 1'b1;
        bus_if.cmd_id    = 4'd14;
        bus_if.cmd_len   = 8'd1;
        bus_if.cmd_user  = 4'd5;
        bus_if.cmd_resp  = 2'b11;
        bus_if.m_axi4_rready = 1'b1;
        check_eq("t3_ready_at_pop", bus_if.cmd_ready, 0);
        check_eq("t3_rlast_first", bus_if.m_axi4_rlast, 1);
        @(posedge clk);
        @(negedge clk);
        check_eq("t3_count_after_pop", bus_if.cmd_count, 3);
        check_eq("t3_ready_after_pop", bus_if.cmd_ready, 1);
        check_eq("t3_no_gap", bus_if.m_axi4_rvalid, 1);
        check_eq("t3_rid_next", bus_if.m_axi4_rid, 11);
        bus_if.m_axi4_rready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        bus_if.cmd_valid = 1'b0;
        check_eq("t3_count_refill", bus_if.cmd_count, 4);
        recv_burst(4'd11, 8'd1, 4'd2, 2'b10, 1'b0);
        recv_burst(4'd12, 8'd2, 4'd3, 2'b01, 1'b0);
        recv_burst(4'd13, 8'd0, 4'd4, 2'b00, 1'b0);
        recv_burst(4'd14, 8'd1, 4'd5, 2'b11, 1'b0);
        check_eq("t3_rvalid_end", bus_if.m_axi4_rvalid, 0);
        check_eq("t3_busy_end", bus_if.busy, 0);

        // Simultaneous push and last-beat pop at count 2
        push_cmd(4'd1, 8'd0, 4'd6, 2'b00);
        push_cmd(4'd2, 8'd1, 4'd7, 2'b01);
        check_eq("t4_count_pre", bus_if.cmd_count, 2);
        bus_if.cmd_valid = 1'b1;
        bus_if.cmd_id    = 4'd4;
        bus_if.cmd_len   = 8'd0;
        bus_if.cmd_user  = 4'd3;
        bus_if.cmd_resp  = 2'b01;
        bus_if.m_axi4_rready = 1'b1;
        check_eq("t4_rlast", bus_if.m_axi4_rlast, 1);
        check_eq("t4_ready", bus_if.cmd_ready, 1);
        @(posedge clk);
        @(negedge clk);
        bus_if.cmd_valid = 1'b0;
        bus_if.m_axi4_rready = 1'b0;
        check_eq("t4_count_same", bus_if.cmd_count, 2);
        check_eq("t4_rid_next", bus_if.m_axi4_rid, 2);
        recv_burst(4'd2, 8'd1, 4'd7, 2'b01, 1'b0);
        recv_burst(4'd4, 8'd0, 4'd3, 2'b01, 1'b0);
        check_eq("t4_count_end", bus_if.cmd_count, 0);

        // Maximum length burst
        push_cmd(4'd7, 8'd255, 4'd15, 2'b10);
        recv_burst(4'd7, 8'd255, 4'd15, 2'b10, 1'b0);
        check_eq("t5_rvalid_end", bus_if.m_axi4_rvalid, 0);
        check_eq("t5_busy_end", bus_if.busy, 0);

        // Reset in the middle of a burst with commands queued behind it
        push_cmd(4'd9, 8'd7, 4'd1, 2'b11);
        push_cmd(4'd5, 8'd0, 4'd2, 2'b00);
        push_cmd(4'd6, 8'd1, 4'd3, 2'b01);
        bus_if.m_axi4_rready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        bus_if.m_axi4_rready = 1'b0;
        check_eq("t6_mid_rvalid", bus_if.m_axi4_rvalid, 1);
        check_eq("t6_mid_rlast", bus_if.m_axi4_rlast, 0);
        rst = 1'b1;
        #1;
        check_eq("t6_rst_rvalid", bus_if.m_axi4_rvalid, 0);
        check_eq("t6_rst_count", bus_if.cmd_count, 0);
        check_eq("t6_rst_ready", bus_if.cmd_ready, 1);
        check_eq("t6_rst_rid", bus_if.m_axi4_rid, 0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus_if.m_axi4_rready = 1'b1;
            check_eq("t6_no_residual", bus_if.m_axi4_rvalid, 0);
            check_eq("t6_count_zero", bus_if.cmd_count, 0);
            @(posedge clk);
            @(negedge clk);
        end
        bus_if.m_axi4_rready = 1'b0;
        push_cmd(4'd6, 8'd1, 4'd4, 2'b10);
        recv_burst(4'd6, 8'd1, 4'd4, 2'b10, 1'b0);
        check_eq("t6_busy_end", bus_if.busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/axi4_r_resp_gen.md
Name: axi4_r_resp_gen

Overview:
- Responder-side counterpart to the RAB's AR request path: generates complete AXI4 R-channel bursts for read requests the RAB terminates locally, e.g. translation misses, protection violations or dropped transactions.
- Upstream logic pushes one command per terminated AR (id, len, user, resp) into a small command FIFO.
- The block then emits len+1 R beats with zero data, the commanded response code and RLAST on the final beat.
- Sits between the RAB miss/error handling logic and the R-channel multiplexer toward the slave port.

Parameters:
- AXI_ID_WIDTH, 4, width of ID fields
- AXI_USER_WIDTH, 4, width of USER fields
- AXI_DATA_WIDTH, 64, width of RDATA
- CMD_DEPTH, 4, command FIFO entries; power of two, >=2

Ports:
- axi4_aclk  input  1  clock
- axi4_arst  input  1  asynchronous reset, active-high
- cmd_valid  input  1  command valid
- cmd_ready  output  1  command accepted when cmd_valid & cmd_ready
- cmd_id  input  AXI_ID_WIDTH  ID to return on RID
- cmd_len  input  8  AXI burst length (beats-1)
- cmd_user  input  AXI_USER_WIDTH  value to return on RUSER
- cmd_resp  input  2  RRESP code for every beat of the burst
- m_axi4_rid  output  AXI_ID_WIDTH  head-command ID
- m_axi4_rdata  output  AXI_DATA_WIDTH  constant zero
- m_axi4_rresp  output  2  head-command resp
- m_axi4_rlast  output  1  final beat of current burst
- m_axi4_ruser  output  AXI_USER_WIDTH  head-command user
- m_axi4_rvalid  output  1  beat valid
- m_axi4_rready  input  1  beat accepted
- busy  output  1  FIFO non-empty or burst in progress
- cmd_count  output  $clog2(CMD_DEPTH)+1  FIFO occupancy

Behaviour:
- Reset, asynchronous and immediate:
  - FIFO empty, read/write pointers = 0, beat_cnt = 0, state = IDLE.
  - Outputs: cmd_ready = 1, rvalid = 0, rlast = 0, busy = 0, cmd_count = 0; rid/rresp/ruser = 0.
  - Reset mid-burst discards all queued and in-flight commands; no further beats are emitted.
- Command FIFO:
  - Registered, CMD_DEPTH entries of {id, len, user, resp}.
  - cmd_ready = (cmd_count != CMD_DEPTH); no full-bypass, so a same-cycle pop when full does not raise cmd_ready.
  - Push on cmd_valid & cmd_ready. Pop only on the last-beat handshake.
  - Simultaneous push and pop leaves cmd_count unchanged.
- FSM, two states:
  - IDLE: FIFO empty; rvalid = 0. Go to SEND when cmd_count becomes non-zero.
  - SEND: rvalid = 1; payload from FIFO head. On a handshake (rvalid & rready):
    - if beat_cnt != head.len: beat_cnt += 1;
    - else: beat_cnt = 0, pop head, stay in SEND if another command remains (count after pop > 0), else go to IDLE.
- Latency:
  - A command pushed in cycle N into an empty FIFO gives rvalid = 1 in cycle N+1; there is no combinational cmd-to-R path.
  - Back-to-back bursts: the first beat of the next command is valid in the cycle after the previous RLAST handshake, with no idle bubble.
- rlast = rvalid & (beat_cnt == head.len). len = 0 gives a single beat with rlast = 1. len = 255 gives 256 beats; beat_cnt is 8 bits and never wraps past len.
- AXI rule: once rvalid is high, rid/rresp/ruser/rlast/rdata remain stable until the handshake; rvalid never drops without a handshake.
- rdata is always 0. rresp is passed unmodified, including OKAY/EXOKAY.
- Pointer wrap-around: pointers are $clog2(CMD_DEPTH) bits and wrap naturally; occupancy is tracked by cmd_count.
- busy = (cmd_count != 0).

Test Plan:
- Reset then single command (id=3, len=0, user=5, resp=2'b10) -> one beat next cycle: rid=3, ruser=5, rresp=10, rlast=1, rdata=0; busy falls the cycle after the handshake.
- Command len=3, rready toggling 1,0,1,0,... -> exactly 4 beats; payload stable during stalls; rlast only on the 4th handshake; beat_cnt returns to 0.
- Push 5 commands back-to-back with rready=0 (CMD_DEPTH=4) -> cmd_ready low after 4 pushes and cmd_count=4; 5th accepted only in the cycle after the first pop; bursts emitted in FIFO order with no gap between RLAST and the next first beat.
- Simultaneous push and last-beat pop at cmd_count=2 -> cmd_count stays 2; the next burst's ID appears in the following cycle.
- Command len=255 with rready=1 -> 256 consecutive beats, rlast only on beat 256, no counter overflow.
- axi4_arst asserted mid-burst (beat 2 of len=7) with queued commands -> rvalid low immediately; after release, cmd_count=0, no residual beats, a new command is served normally.
